// File: rtl/a2d_pkg.sv
// Shared types and sizes for the A2D channel scanner.
package a2d_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned RES_W  = 12;
  localparam int unsigned AVG_N  = 4;
  localparam int unsigned ACC_W  = 14;
  localparam int unsigned SAMP_W = $clog2(AVG_N);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_START,
    ST_WAIT_CMPLT,
    ST_GAP
  } scan_state_e;

  // Index of the channel after ch; 8 means "past the last channel".
  function automatic logic [IDX_W-1:0] next_idx(input logic [CH_W-1:0] ch);
    return IDX_W'(ch) + IDX_W'(1);
  endfunction

endpackage

// File: rtl/a2d_ch_pick.sv
// Finds the lowest enabled channel at or above ch_idx; found=0 when none remain.
module a2d_ch_pick
  import a2d_pkg::*;
(
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [IDX_W-1:0]  ch_idx,
  output logic              found,
  output logic [CH_W-1:0]   ch
);

  // Scan downward so the lowest qualifying channel is the last one written.
  always_comb begin
    found = 1'b0;
    ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i] && (IDX_W'(i) >= ch_idx)) begin
        found = 1'b1;
        ch    = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/a2d_scan_ctrl.sv
// Autonomous A2D channel scanner with per-channel result/valid/err registers.
// Define A2D_SCAN_AVG_EN to convert each channel AVG_N times and store the average.
module a2d_scan_ctrl
  import a2d_pkg::*;
#(
  parameter int unsigned SCAN_GAP = 1000,
  parameter int unsigned TIMEOUT  = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_en,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              strt_cnv,
  output logic [CH_W-1:0]   chnnl,
  input  logic              cnv_cmplt,
  input  logic [RES_W-1:0]  res,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [RES_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] valid,
  output logic [NUM_CH-1:0] err,
  output logic              scan_done
);

  localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP + 1) : 1;

  scan_state_e      state;
  logic [IDX_W-1:0] ch_idx;
  logic [RES_W-1:0] result [NUM_CH];
  logic [TMO_W-1:0] tmo_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             ran_any;
  logic             pick_found;
  logic [CH_W-1:0]  pick_ch;

`ifdef A2D_SCAN_AVG_EN
  logic [ACC_W-1:0]  acc;
  logic [SAMP_W-1:0] samp_cnt;
  logic [ACC_W-1:0]  acc_sum;

  assign acc_sum = acc + ACC_W'(res);
`endif

  a2d_ch_pick u_ch_pick (
    .ch_mask (ch_mask),
    .ch_idx  (ch_idx),
    .found   (pick_found),
    .ch      (pick_ch)
  );

  // A same-cycle write lands on the clock edge, so a concurrent read sees the old value.
  assign rd_data = result[rd_ch];

  // Scan sequencer, timers and result storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ch_idx    <= '0;
      chnnl     <= '0;
      strt_cnv  <= 1'b0;
      scan_done <= 1'b0;
      valid     <= '0;
      err       <= '0;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
      ran_any   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        result[i] <= '0;
      end
`ifdef A2D_SCAN_AVG_EN
      acc      <= '0;
      samp_cnt <= '0;
`endif
    end else begin
      strt_cnv  <= 1'b0;
      scan_done <= 1'b0;

      unique case (state)
        ST_IDLE: begin
`ifdef A2D_SCAN_AVG_EN
          acc      <= '0;
          samp_cnt <= '0;
`endif
          if (scan_en) begin
            ch_idx  <= '0;
            ran_any <= 1'b0;
            state   <= ST_SELECT;
          end
        end

        ST_SELECT: begin
          if (!scan_en) begin
            state <= ST_IDLE;
          end else if (pick_found) begin
            chnnl    <= pick_ch;
            strt_cnv <= 1'b1;
            tmo_cnt  <= TMO_W'(TIMEOUT - 1);
            ran_any  <= 1'b1;
            state    <= ST_START;
          end else begin
            // An all-zero mask never starts a conversion, so no scan_done either.
            scan_done <= ran_any;
            gap_cnt   <= GAP_W'(SCAN_GAP);
            state     <= ST_GAP;
          end
        end

        ST_START: begin
          // The timeout window starts with the strt_cnv pulse itself.
          if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
          state <= scan_en ? ST_WAIT_CMPLT : ST_IDLE;
        end

        ST_WAIT_CMPLT: begin
          if (cnv_cmplt) begin
`ifdef A2D_SCAN_AVG_EN
            if (samp_cnt == SAMP_W'(AVG_N - 1)) begin
              result[chnnl] <= acc_sum[ACC_W-1 -: RES_W];
              valid[chnnl]  <= 1'b1;
              err[chnnl]    <= 1'b0;
              acc           <= '0;
              samp_cnt      <= '0;
              ch_idx        <= next_idx(chnnl);
              state         <= scan_en ? ST_SELECT : ST_IDLE;
            end else if (!scan_en) begin
              // Partial average is discarded; IDLE clears the accumulator.
              state <= ST_IDLE;
            end else begin
              acc      <= acc_sum;
              samp_cnt <= samp_cnt + SAMP_W'(1);
              strt_cnv <= 1'b1;
              tmo_cnt  <= TMO_W'(TIMEOUT - 1);
              state    <= ST_START;
            end
`else
            result[chnnl] <= res;
            valid[chnnl]  <= 1'b1;
            err[chnnl]    <= 1'b0;
            ch_idx        <= next_idx(chnnl);
            state         <= scan_en ? ST_SELECT : ST_IDLE;
`endif
          end else if (tmo_cnt == '0) begin
            err[chnnl]   <= 1'b1;
            valid[chnnl] <= 1'b0;
            ch_idx       <= next_idx(chnnl);
            state        <= scan_en ? ST_SELECT : ST_IDLE;
`ifdef A2D_SCAN_AVG_EN
            acc      <= '0;
            samp_cnt <= '0;
`endif
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end

        ST_GAP: begin
          if (!scan_en) begin
            state <= ST_IDLE;
          end else if (gap_cnt == '0) begin
            ch_idx  <= '0;
            ran_any <= 1'b0;
            state   <= ST_SELECT;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Directed bench for a2d_scan_ctrl with a behavioural A2D responder (fixed latency).
module tb_a2d_scan_ctrl;

`ifdef A2D_SCAN_AVG_EN
  localparam int NS = 4;
`else
  localparam int NS = 1;
`endif
  localparam int MODEL_LAT = 10;

  logic        clk;
  logic        rst_n;
  logic        scan_en;
  logic [7:0]  ch_mask;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic [2:0]  rd_ch;
  logic [11:0] rd_data;
  logic [7:0]  valid;
  logic [7:0]  err;
  logic        scan_done;

  logic        model_en;
  logic        seq_mode;
  int          seq_k;
  int          resp_cnt;
  logic [2:0]  ch_l;

  int strt_cnt [8];
  int strt_total;
  int sd_cnt;
  int checks;
  int failures;

  a2d_scan_ctrl #(.SCAN_GAP(100), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_en   (scan_en),
    .ch_mask   (ch_mask),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .res       (res),
    .rd_ch     (rd_ch),
    .rd_data   (rd_data),
    .valid     (valid),
    .err       (err),
    .scan_done (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] model_val(input logic [2:0] ch);
    return 12'h123 + 12'(ch) * 12'h111;
  endfunction

  // A2D responder: one-cycle cnv_cmplt MODEL_LAT clocks after strt_cnv.
  initial begin
    cnv_cmplt = 1'b0;
    res       = '0;
    seq_k     = 0;
    resp_cnt  = 0;
    ch_l      = '0;
    forever begin
      @(negedge clk);
      cnv_cmplt = 1'b0;
      if (!seq_mode) seq_k = 0;
      if (strt_cnv && model_en && rst_n) begin
        ch_l = chnnl;
        repeat (MODEL_LAT) @(negedge clk);
        if (rst_n) begin
          cnv_cmplt = 1'b1;
          res       = seq_mode ? (12'h100 + 12'(seq_k)) : model_val(ch_l);
          seq_k++;
          resp_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && strt_cnv) begin
      strt_cnt[chnnl]++;
      strt_total++;
    end
    if (rst_n && scan_done) sd_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    scan_en  = 1'b0;
    ch_mask  = 8'h00;
    rd_ch    = 3'd0;
    model_en = 1'b1;
    seq_mode = 1'b0;
    rst_n    = 1'b0;
    repeat (15) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int max, output bit ok);
    int base;
    base = sd_cnt;
    ok   = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      if (sd_cnt != base) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    scan_en  = 1'b0;
    ch_mask  = 8'hFF;
    model_en = 1'b1;
    seq_mode = 1'b0;
    rst_n    = 1'b0;
    repeat (3) tick();
    checks++; if (strt_cnv !== 1'b0) begin failures++; $display("FAIL reset_strt: got %b want 0", strt_cnv); end
    checks++; if (chnnl !== 3'd0) begin failures++; $display("FAIL reset_chnnl: got %0d want 0", chnnl); end
    checks++; if (scan_done !== 1'b0) begin failures++; $display("FAIL reset_scan_done: got %b want 0", scan_done); end
    checks++; if (valid !== 8'h00 || err !== 8'h00) begin failures++; $display("FAIL reset_flags: valid=%h err=%h want 00/00", valid, err); end
    rd_ch = 3'd5; #1;
    checks++; if (rd_data !== 12'h000) begin failures++; $display("FAIL reset_rd_data: got %h want 000", rd_data); end
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (strt_total !== 0) begin failures++; $display("FAIL idle_no_strt: got %0d want 0", strt_total); end
  endtask

  task automatic test_scan_mask();
    int  base_cnt [8];
    int  base_total;
    int  base_sd;
    bit  ok;
    do_reset();
    base_cnt   = strt_cnt;
    base_total = strt_total;
    base_sd    = sd_cnt;
    ch_mask = 8'h0A;
    scan_en = 1'b1;
    wait_done(500, ok);
    scan_en = 1'b0;
    repeat (5) tick();
    checks++; if (!ok) begin failures++; $display("FAIL scan_done_timeout: got none want pulse"); end
    checks++; if (strt_cnt[1] - base_cnt[1] !== NS) begin failures++; $display("FAIL strt_ch1: got %0d want %0d", strt_cnt[1] - base_cnt[1], NS); end
    checks++; if (strt_cnt[3] - base_cnt[3] !== NS) begin failures++; $display("FAIL strt_ch3: got %0d want %0d", strt_cnt[3] - base_cnt[3], NS); end
    checks++; if (strt_total - base_total !== 2 * NS) begin failures++; $display("FAIL strt_total: got %0d want %0d", strt_total - base_total, 2 * NS); end
    checks++; if (sd_cnt - base_sd !== 1) begin failures++; $display("FAIL scan_done_count: got %0d want 1", sd_cnt - base_sd); end
    checks++; if (valid !== 8'h0A || err !== 8'h00) begin failures++; $display("FAIL scan_flags: valid=%h err=%h want 0a/00", valid, err); end
    rd_ch = 3'd1; #1;
    checks++; if (rd_data !== 12'h234) begin failures++; $display("FAIL rd_ch1: got %h want 234", rd_data); end
    rd_ch = 3'd3; #1;
    checks++; if (rd_data !== 12'h456) begin failures++; $display("FAIL rd_ch3: got %h want 456", rd_data); end
    rd_ch = 3'd0; #1;
    checks++; if (rd_data !== 12'h000) begin failures++; $display("FAIL rd_ch0_untouched: got %h want 000", rd_data); end
  endtask

  task automatic test_drop_mid();
    int         base3;
    int         base_total;
    bit         seen;
    logic       exp_v3;
    logic [11:0] exp_rd3;
    do_reset();
    exp_v3  = (NS == 1);
    exp_rd3 = (NS == 1) ? 12'h456 : 12'h000;
    base3   = strt_cnt[3];
    ch_mask = 8'h0A;
    scan_en = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (strt_cnt[3] != base3) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL drop_strt_ch3: got none want pulse"); end
    repeat (3) tick();
    scan_en    = 1'b0;
    base_total = strt_total;
    repeat (60) tick();
    checks++; if (valid[3] !== exp_v3) begin failures++; $display("FAIL drop_valid3: got %b want %b", valid[3], exp_v3); end
    checks++; if (valid[1] !== 1'b1 || err !== 8'h00) begin failures++; $display("FAIL drop_flags: valid=%h err=%h want ch1 valid, err 00", valid, err); end
    rd_ch = 3'd3; #1;
    checks++; if (rd_data !== exp_rd3) begin failures++; $display("FAIL drop_rd_ch3: got %h want %h", rd_data, exp_rd3); end
    checks++; if (strt_total !== base_total) begin failures++; $display("FAIL drop_no_more_strt: got %0d extra want 0", strt_total - base_total); end
  endtask

  task automatic test_timeout();
    int base_total;
    bit seen;
    bit ok;
    do_reset();
    model_en   = 1'b0;
    base_total = strt_total;
    ch_mask    = 8'h01;
    scan_en    = 1'b1;
    seen       = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (strt_total != base_total) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL tmo_strt: got none want pulse"); end
    repeat (63) tick();
    checks++; if (err[0] !== 1'b0) begin failures++; $display("FAIL tmo_early: err0=%b at 63 clocks want 0", err[0]); end
    tick();
    checks++; if (err[0] !== 1'b1 || valid[0] !== 1'b0) begin failures++; $display("FAIL tmo_flag: err0=%b valid0=%b at 64 clocks want 1/0", err[0], valid[0]); end
    wait_done(5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL tmo_scan_done: got none want pulse"); end
    rd_ch = 3'd0; #1;
    checks++; if (rd_data !== 12'h000) begin failures++; $display("FAIL tmo_result_kept: got %h want 000", rd_data); end
    model_en = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (valid[0]) seen = 1'b1;
    end
    scan_en = 1'b0;
    checks++; if (!seen || err[0] !== 1'b0) begin failures++; $display("FAIL tmo_recover: valid0=%b err0=%b want 1/0", valid[0], err[0]); end
    checks++; if (rd_data !== 12'h123) begin failures++; $display("FAIL tmo_recover_rd: got %h want 123", rd_data); end
  endtask

  task automatic test_empty_mask();
    int base_total;
    int base_sd;
    do_reset();
    base_total = strt_total;
    base_sd    = sd_cnt;
    ch_mask    = 8'h00;
    scan_en    = 1'b1;
    repeat (10000) tick();
    scan_en = 1'b0;
    checks++; if (strt_total !== base_total) begin failures++; $display("FAIL empty_strt: got %0d want 0", strt_total - base_total); end
    checks++; if (sd_cnt !== base_sd) begin failures++; $display("FAIL empty_scan_done: got %0d want 0", sd_cnt - base_sd); end
    checks++; if (valid !== 8'h00) begin failures++; $display("FAIL empty_valid: got %h want 00", valid); end
  endtask

  task automatic test_gap();
    int base_total;
    int n;
    int bad;
    bit ok;
    bit seen;
    do_reset();
    ch_mask = 8'h80;
    scan_en = 1'b1;
    wait_done(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL gap_first_done: got none want pulse"); end
    checks++; if (valid !== 8'h80) begin failures++; $display("FAIL gap_valid: got %h want 80", valid); end
    rd_ch = 3'd7; #1;
    checks++; if (rd_data !== 12'h89A) begin failures++; $display("FAIL gap_rd_ch7: got %h want 89a", rd_data); end
    base_total = strt_total;
    n = 0;
    while (strt_total == base_total && n < 300) begin
      tick();
      n++;
    end
    checks++; if (n !== 102) begin failures++; $display("FAIL gap_length: got %0d clocks want 102", n); end
    bad  = (chnnl !== 3'd7) ? 1 : 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (chnnl !== 3'd7) bad++;
      if (cnv_cmplt) seen = 1'b1;
    end
    scan_en = 1'b0;
    checks++; if (!seen || bad !== 0) begin failures++; $display("FAIL gap_chnnl_hold: cmplt_seen=%b unstable=%0d want 1/0", seen, bad); end
  endtask

  task automatic test_reset_mid();
    int  base_total;
    bit  seen;
    do_reset();
    base_total = strt_total;
    ch_mask    = 8'h0A;
    scan_en    = 1'b1;
    seen       = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (strt_total != base_total) seen = 1'b1;
    end
    repeat (2) tick();
    scan_en = 1'b0;
    rst_n   = 1'b0;
    #1;
    checks++; if (!seen || chnnl !== 3'd0 || strt_cnv !== 1'b0) begin failures++; $display("FAIL rst_mid_async: seen=%b chnnl=%0d strt=%b want 1/0/0", seen, chnnl, strt_cnv); end
    tick();
    rst_n      = 1'b1;
    base_total = strt_total;
    repeat (30) tick();
    checks++; if (valid !== 8'h00 || strt_total !== base_total) begin failures++; $display("FAIL rst_mid_idle: valid=%h strt=%0d want 00/0", valid, strt_total - base_total); end
  endtask

`ifdef A2D_SCAN_AVG_EN
  task automatic test_avg();
    int base0;
    int base_resp;
    bit seen;
    bit ok;
    do_reset();
    seq_mode  = 1'b1;
    base0     = strt_cnt[0];
    base_resp = resp_cnt;
    ch_mask   = 8'h01;
    scan_en   = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (resp_cnt - base_resp == 3) seen = 1'b1;
    end
    repeat (2) tick();
    checks++; if (!seen || valid[0] !== 1'b0) begin failures++; $display("FAIL avg_early_valid: seen=%b valid0=%b want 1/0", seen, valid[0]); end
    wait_done(200, ok);
    scan_en = 1'b0;
    checks++; if (!ok || strt_cnt[0] - base0 !== 4) begin failures++; $display("FAIL avg_strt: got %0d want 4", strt_cnt[0] - base0); end
    rd_ch = 3'd0; #1;
    checks++; if (rd_data !== 12'h101 || valid !== 8'h01) begin failures++; $display("FAIL avg_result: rd=%h valid=%h want 101/01", rd_data, valid); end
  endtask
`endif

  initial begin
    checks     = 0;
    failures   = 0;
    strt_total = 0;
    sd_cnt     = 0;
    scan_en    = 1'b0;
    ch_mask    = 8'h00;
    rd_ch      = 3'd0;
    model_en   = 1'b1;
    seq_mode   = 1'b0;
    rst_n      = 1'b0;
    test_reset();
    test_scan_mask();
    test_drop_mid();
    test_timeout();
    test_empty_mask();
    test_gap();
    test_reset_mid();
`ifdef A2D_SCAN_AVG_EN
    test_avg();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
